// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result valid-ready bundle for pipe_adder
interface pipe_adder_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  i_valid;
  logic                  o_ready;
  logic [1:0]            i_op;
  logic [DATA_WIDTH-1:0] i_input1;
  logic [DATA_WIDTH-1:0] i_input2;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_sum;
  logic                  o_carry;
  logic                  o_overflow;
  modport master (
    output i_valid, i_op, i_input1, i_input2, i_ready,
    input  o_ready, o_valid, o_sum, o_carry, o_overflow
  );
  modport slave (
    input  i_valid, i_op, i_input1, i_input2, i_ready,
    output o_ready, o_valid, o_sum, o_carry, o_overflow
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: carry-chained adder split into STAGES chunk-wide pipeline stages with valid/ready flow control
module pipe_adder #(
  parameter int DATA_WIDTH = 64,
  parameter int STAGES     = 4,
  parameter int CHUNK      = DATA_WIDTH / STAGES
) (
  input  logic         i_clk,
  input  logic         i_arst_n,
  input  logic         i_flush,
  pipe_adder_if.slave  bus
);
  localparam int L = STAGES - 1;
  localparam int M = DATA_WIDTH - 1;
  logic [STAGES-1:0]                 v_q, v_d, c_q, c_d, c_n;
  logic [STAGES-1:0][1:0]            op_q, op_d;
  logic [STAGES-1:0][DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, s_n;
  logic [STAGES:0]                   v_p, c_p;
  logic [STAGES:0][1:0]              op_p;
  logic [STAGES:0][DATA_WIDTH-1:0]   a_p, b_p, s_p;
  logic                              adv;
  logic [DATA_WIDTH-1:0]             s_l, a_l, b_l;
  logic [1:0]                        op_l;
  logic                              c_l;
  assign adv         = !v_q[L] || bus.i_ready;
  assign bus.o_ready = adv;
  assign bus.o_valid = v_q[L];
  // index 0 is the incoming operation; index k+1 is the output of stage k
  always_comb begin
    v_p[0]  = bus.i_valid;
    op_p[0] = bus.i_op;
    a_p[0]  = bus.i_input1;
    b_p[0]  = bus.i_op[0] ? ~bus.i_input2 : bus.i_input2;
    s_p[0]  = '0;
    c_p[0]  = bus.i_op[0];
    for (int k = 0; k < STAGES; k++) begin
      v_p[k+1]  = v_q[k];
      op_p[k+1] = op_q[k];
      a_p[k+1]  = a_q[k];
      b_p[k+1]  = b_q[k];
      s_p[k+1]  = s_q[k];
      c_p[k+1]  = c_q[k];
    end
  end
  always_comb begin
    s_n = s_p[STAGES-1:0];
    c_n = '0;
    for (int k = 0; k < STAGES; k++)
      {c_n[k], s_n[k][k*CHUNK +: CHUNK]} = {1'b0, a_p[k][k*CHUNK +: CHUNK]}
                                         + {1'b0, b_p[k][k*CHUNK +: CHUNK]}
                                         + {{CHUNK{1'b0}}, c_p[k]};
  end
  always_comb begin
    v_d  = i_flush ? '0 : adv ? v_p[STAGES-1:0] : v_q;
    op_d = adv ? op_p[STAGES-1:0] : op_q;
    a_d  = adv ? a_p[STAGES-1:0] : a_q;
    b_d  = adv ? b_p[STAGES-1:0] : b_q;
    s_d  = adv ? s_n : s_q;
    c_d  = adv ? c_n : c_q;
  end
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      v_q  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
      c_q  <= '0;
    end else begin
      v_q  <= v_d;
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
      s_q  <= s_d;
      c_q  <= c_d;
    end
  assign s_l  = s_q[L];
  assign a_l  = a_q[L];
  assign b_l  = b_q[L];
  assign op_l = op_q[L];
  assign c_l  = c_q[L];
  if (DATA_WIDTH == 64) begin : g_w
    logic w;
    assign w = op_l[1];
    // carry into bit 32 recovered from the full sum: s = a ^ b' ^ cin
    assign bus.o_sum      = w ? {{32{s_l[31]}}, s_l[31:0]} : s_l;
    assign bus.o_carry    = w ? s_l[32] ^ a_l[32] ^ b_l[32] : c_l;
    assign bus.o_overflow = w ? (a_l[31] == b_l[31]) && (s_l[31] != a_l[31])
                              : (a_l[M] == b_l[M]) && (s_l[M] != a_l[M]);
  end else begin : g_nw
    logic unused_w;
    assign unused_w       = op_l[1];
    assign bus.o_sum      = s_l;
    assign bus.o_carry    = c_l;
    assign bus.o_overflow = (a_l[M] == b_l[M]) && (s_l[M] != a_l[M]);
  end
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed vectors against an arithmetic scoreboard for pipe_adder
module tb_pipe_adder;
  localparam int DW = 64;
  localparam int ST = 4;
  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        o;
  } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  res_t q[$];
  pipe_adder_if #(.DATA_WIDTH(DW)) bus ();
  pipe_adder #(.DATA_WIDTH(DW), .STAGES(ST)) dut (
    .i_clk   (clk),
    .i_arst_n(rst_n),
    .i_flush (flush),
    .bus     (bus.slave)
  );
  always #5 clk = ~clk;
  function automatic res_t model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    res_t r;
    logic [64:0] t;
    logic [32:0] u;
    r = '0;
    u = '0;
    if (!op[1]) begin
      if (op[0]) begin
        r.s = a - b;
        r.c = a >= b;
        r.o = (a[63] != b[63]) && (r.s[63] != a[63]);
      end else begin
        t = {1'b0, a} + {1'b0, b};
        r.s = t[63:0];
        r.c = t[64];
        r.o = (a[63] == b[63]) && (r.s[63] != a[63]);
      end
    end else begin
      if (op[0]) begin
        u[31:0] = a[31:0] - b[31:0];
        u[32]   = a[31:0] >= b[31:0];
        r.o     = (a[31] != b[31]) && (u[31] != a[31]);
      end else begin
        u   = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        r.o = (a[31] == b[31]) && (u[31] != a[31]);
      end
      r.s = {{32{u[31]}}, u[31:0]};
      r.c = u[32];
    end
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(negedge rst_n) q.delete();
  always @(negedge clk) if (rst_n) begin
    if (bus.o_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual o_sum=%h required=no result pending", bus.o_sum);
      end else begin
        chk("o_sum", bus.o_sum, q[0].s);
        chk("o_carry", 64'(bus.o_carry), 64'(q[0].c));
        chk("o_overflow", 64'(bus.o_overflow), 64'(q[0].o));
        if (bus.i_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
    end
    chk("o_ready", 64'(bus.o_ready), 64'(!bus.o_valid || bus.i_ready));
    if (flush) q.delete();
    else if (bus.i_valid && bus.o_ready) q.push_back(model(bus.i_op, bus.i_input1, bus.i_input2));
  end
  task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic acc;
    int n;
    bus.i_valid  = 1'b1;
    bus.i_op     = op;
    bus.i_input1 = a;
    bus.i_input2 = b;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.o_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 64'(n), 64'(0));
  endtask
  task automatic run_one(input string name, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] es, input logic ec, input logic eo);
    int n;
    send(op, a, b);
    bus.i_valid = 1'b0;
    n = 1;
    while (!bus.o_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(ST));
    chk({name, "_sum"}, bus.o_sum, es);
    chk({name, "_carry"}, 64'(bus.o_carry), 64'(ec));
    chk({name, "_ovf"}, 64'(bus.o_overflow), 64'(eo));
    @(posedge clk);
    #1;
  endtask
  initial begin
    int base;
    bus.i_valid  = 1'b0;
    bus.i_op     = 2'b00;
    bus.i_input1 = '0;
    bus.i_input2 = '0;
    bus.i_ready  = 1'b1;
    #3;
    chk("rst_o_valid", 64'(bus.o_valid), 64'(0));
    chk("rst_o_sum", bus.o_sum, 64'h0);
    chk("rst_o_carry", 64'(bus.o_carry), 64'(0));
    chk("rst_o_ovf", 64'(bus.o_overflow), 64'(0));
    chk("rst_o_ready", 64'(bus.o_ready), 64'(1));
    chk("model_add_chain", model(2'b00, 64'h0000_0000_FFFF_FFFF, 64'h1).s, 64'h0000_0001_0000_0000);
    chk("model_sub_borrow", 64'(model(2'b01, 64'd5, 64'd7)), {63'h7FFF_FFFF_FFFF_FFFF, 1'b0} << 2);
    chk("model_sub_pos", 64'(model(2'b01, 64'd7, 64'd5)), (64'd2 << 2) | 64'd2);
    chk("model_addw_ovf", model(2'b10, 64'h7FFF_FFFF, 64'h1).s, 64'hFFFF_FFFF_8000_0000);
    chk("model_add_ovf", 64'(model(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1).o), 64'(1));
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_one("add_chain", 2'b00, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
    run_one("sub_5_7", 2'b01, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_7_5", 2'b01, 64'd7, 64'd5, 64'd2, 1'b1, 1'b0);
    run_one("addw_ovf", 2'b10, 64'h7FFF_FFFF, 64'h1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1);
    run_one("add_ovf", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_one("subw_0_1", 2'b11, 64'h1234_5678_0000_0000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_one("add_wrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0);
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(2'(i), 64'h0123_4567_89AB_CDEF * 64'(i + 1), 64'hFEDC_BA98_7654_3210 ^ (64'(i) << 60));
        bus.i_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          bus.i_ready = (i % 3) == 0;
          @(posedge clk);
          #1;
        end
        bus.i_ready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_count", 64'(n_out - base), 64'd8);
    chk("b2b_drained", 64'(q.size()), 64'd0);
    send(2'b00, 64'd1, 64'd2);
    send(2'b01, 64'd9, 64'd3);
    send(2'b10, 64'd4, 64'd4);
    bus.i_valid = 1'b1;
    bus.i_input1 = 64'hDEAD;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.i_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("flush_quiet", 64'(bus.o_valid), 64'(0));
      @(posedge clk);
      #1;
    end
    run_one("post_flush", 2'b00, 64'd100, 64'd23, 64'd123, 1'b0, 1'b0);
    send(2'b00, 64'd10, 64'd20);
    send(2'b00, 64'd30, 64'd40);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_reset_valid", 64'(bus.o_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.o_valid), 64'(0));
    chk("async_rst_sum", bus.o_sum, 64'h0);
    chk("async_rst_ready", 64'(bus.o_ready), 64'(1));
    #3;
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_quiet", 64'(bus.o_valid), 64'(0));
    end
    chk("final_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
